// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline types and constants for hazard detection
package hazard_stall_unit_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } slot_t;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_STALL_1 = 2'd1,
        HZ_STALL_2 = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_eq_nonzero_5.sv
// eq_nonzero_5: 5-bit register equality that never matches register zero
module eq_nonzero_5
    import hazard_stall_unit_pkg::*;
(
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic       eq
);

    assign eq = (a == b) && (a != REG_ZERO);

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and branch-operand hazard detector with stall counter
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cycles
);

    slot_t     ex_q, mem_q, ex_d;
    hz_state_t state_q, state_d;
    logic      rs_ex_eq, rt_ex_eq, rs_mem_eq, rt_mem_eq;
    logic      hit_ex, hit_mem, load_use, br_hz;

    eq_nonzero_5 u_rs_ex  (.a(id_rs), .b(ex_q.rd),  .eq(rs_ex_eq));
    eq_nonzero_5 u_rt_ex  (.a(id_rt), .b(ex_q.rd),  .eq(rt_ex_eq));
    eq_nonzero_5 u_rs_mem (.a(id_rs), .b(mem_q.rd), .eq(rs_mem_eq));
    eq_nonzero_5 u_rt_mem (.a(id_rt), .b(mem_q.rd), .eq(rt_mem_eq));

    assign hit_ex   = ex_q.valid & ex_q.regwrite & ((id_uses_rs & rs_ex_eq) | (id_uses_rt & rt_ex_eq));
    assign hit_mem  = mem_q.valid & mem_q.regwrite & ((id_uses_rs & rs_mem_eq) | (id_uses_rt & rt_mem_eq));
    assign load_use = hit_ex & ex_q.memread;
    assign br_hz    = id_is_branch & (hit_ex | (hit_mem & mem_q.memread));
    assign stall    = id_valid & ~flush & (load_use | br_hz);
    assign bubble   = stall;
    assign hz_state = state_q;

    // next FSM state and next EX slot; STALL_2 holds if a third stall is requested
    always_comb begin
        state_d = (state_q == HZ_RUN)     ? (stall ? HZ_STALL_1 : HZ_RUN) :
                  (state_q == HZ_STALL_1) ? (stall ? HZ_STALL_2 : HZ_RUN) :
                                            (stall ? HZ_STALL_2 : HZ_RUN);
        ex_d    = (stall | flush | ~id_valid) ? slot_t'('0) :
                  slot_t'({1'b1, id_rd, id_regwrite, id_memread});
    end

    // shadow slots, FSM state and saturating stall counter
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q         <= '0;
            mem_q        <= '0;
            state_q      <= HZ_RUN;
            stall_cycles <= '0;
        end else begin
            ex_q         <= ex_d;
            mem_q        <= ex_q;
            state_q      <= state_d;
            stall_cycles <= (stall && stall_cycles != {CNT_W{1'b1}}) ? stall_cycles + CNT_W'(1) : stall_cycles;
        end
    end

endmodule
